// File: rtl/vga_timing_gen.sv
// VGA/DVI timing generator: free-running h/v counters produce de/hs/vs, and active
// pixels are pulled from a valid/ready stream into registered video outputs.
module vga_timing_gen #(
    parameter int H_RES  = 16,
    parameter int H_FP   = 3,
    parameter int H_SYNC = 1,
    parameter int H_BP   = 3,
    parameter int V_RES  = 16,
    parameter int V_FP   = 128,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 128,
    parameter int HS_POL = 0,
    parameter int VS_POL = 0,
    parameter int DW     = 8,
    parameter int CH     = 3,
    parameter int CNT_W  = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CH*DW-1:0] pix_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic             underflow_clr,
    output logic [CH*DW-1:0] vga_data,
    output logic             vga_de,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic [CNT_W-1:0] vga_x,
    output logic [CNT_W-1:0] vga_y,
    output logic             sof,
    output logic             underflow
);

    localparam int H_TOT = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_RES + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_RES_C  = CNT_W'(H_RES);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_RES + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_RES + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_RES_C  = CNT_W'(V_RES);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_RES + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_RES + V_FP + V_SYNC);
    localparam logic             HS_ACT   = 1'(HS_POL);
    localparam logic             VS_ACT   = 1'(VS_POL);

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic [CH*DW-1:0] data_q, data_d;
    logic             de_q, de_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             sof_q, sof_d;
    logic             uflow_q, uflow_d;

    logic active, hs_on, vs_on, run_active;

    always_comb begin
        active     = (hcnt_q < H_RES_C) && (vcnt_q < V_RES_C);
        hs_on      = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
        vs_on      = (vcnt_q >= VS_START) && (vcnt_q < VS_END);
        run_active = en && active;
        pix_ready  = run_active && !rst;

        // Explicit wrap at the last count; en=0 parks the raster at the frame origin.
        hcnt_d = '0;
        vcnt_d = '0;
        if (en) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CNT_W'(1);
            end else begin
                hcnt_d = hcnt_q + CNT_W'(1);
                vcnt_d = vcnt_q;
            end
        end

        de_d    = run_active;
        hs_d    = (en && hs_on) ? HS_ACT : ~HS_ACT;
        vs_d    = (en && vs_on) ? VS_ACT : ~VS_ACT;
        data_d  = (pix_ready && pix_valid) ? pix_data : '0;
        x_d     = run_active ? hcnt_q : '0;
        y_d     = run_active ? vcnt_q : '0;
        sof_d   = run_active && (hcnt_q == '0) && (vcnt_q == '0);
        // A missing pixel in an active slot wins over a simultaneous clear.
        uflow_d = (run_active && !pix_valid) || (uflow_q && !underflow_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            data_q  <= '0;
            de_q    <= 1'b0;
            hs_q    <= ~HS_ACT;
            vs_q    <= ~VS_ACT;
            x_q     <= '0;
            y_q     <= '0;
            sof_q   <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            data_q  <= data_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sof_q   <= sof_d;
            uflow_q <= uflow_d;
        end
    end

    assign vga_data  = data_q;
    assign vga_de    = de_q;
    assign vga_hs    = hs_q;
    assign vga_vs    = vs_q;
    assign vga_x     = x_q;
    assign vga_y     = y_q;
    assign sof       = sof_q;
    assign underflow = uflow_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on an 8x6 raster (4x3 active), with active-low and
// active-high sync instances driven by the same stimulus.
module tb_vga_timing_gen;

    localparam int DW = 8;
    localparam int CH = 3;
    localparam int CW = 11;

    logic              clk = 1'b0;
    logic              rst, en, pix_valid, underflow_clr;
    logic [CH*DW-1:0]  pix_data;

    logic              rdy, de, hs, vs, sof, uf;
    logic [CH*DW-1:0]  vdata;
    logic [CW-1:0]     vx, vy;

    logic              rdy2, de2, hs2, vs2, sof2, uf2;
    logic [CH*DW-1:0]  vdata2;
    logic [CW-1:0]     vx2, vy2;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_RES(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_RES(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .DW(DW), .CH(CH), .CNT_W(CW)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(rdy),
        .underflow_clr(underflow_clr),
        .vga_data(vdata), .vga_de(de), .vga_hs(hs), .vga_vs(vs),
        .vga_x(vx), .vga_y(vy), .sof(sof), .underflow(uf)
    );

    vga_timing_gen #(
        .H_RES(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_RES(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .DW(DW), .CH(CH), .CNT_W(CW)
    ) u_dut_pos (
        .clk(clk), .rst(rst), .en(en),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(rdy2),
        .underflow_clr(underflow_clr),
        .vga_data(vdata2), .vga_de(de2), .vga_hs(hs2), .vga_vs(vs2),
        .vga_x(vx2), .vga_y(vy2), .sof(sof2), .underflow(uf2)
    );

    typedef struct {
        logic        vld;
        logic        de;
        logic        hs;
        logic        vs;
        logic        sof;
        logic [23:0] data;
        logic [10:0] x;
        logic [10:0] y;
    } vec_t;

    vec_t        tbl [48];
    int          checks = 0;
    int          errors = 0;
    logic [23:0] src;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One pixel clock: present src with the given valid, advance src on a transfer.
    task automatic cycle(input logic v);
        logic xfer;
        pix_valid = v;
        pix_data  = src;
        #1;
        xfer = rdy && v;
        @(posedge clk);
        #1;
        if (xfer) src = src + 24'd1;
    endtask

    initial begin
        int k;
        int hc, vc;
        logic [23:0] held;

        k = 0;
        for (int c = 0; c < 48; c++) begin
            hc = c % 8;
            vc = c / 8;
            tbl[c].vld  = 1'b1;
            tbl[c].de   = (hc < 4) && (vc < 3);
            tbl[c].hs   = !(hc == 5 || hc == 6);
            tbl[c].vs   = (vc != 4);
            tbl[c].sof  = (c == 0);
            tbl[c].data = 24'd0;
            tbl[c].x    = 11'd0;
            tbl[c].y    = 11'd0;
            if (tbl[c].de) begin
                k++;
                tbl[c].data = 24'(k);
                tbl[c].x    = 11'(hc);
                tbl[c].y    = 11'(vc);
            end
        end

        rst = 1'b1; en = 1'b1; pix_valid = 1'b0; pix_data = '0; underflow_clr = 1'b0;
        src = 24'd1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_de", 32'(de), 32'd0);
        chk("reset_hs", 32'(hs), 32'd1);
        chk("reset_vs", 32'(vs), 32'd1);
        chk("reset_data", 32'(vdata), 32'd0);
        chk("reset_ready", 32'(rdy), 32'd0);
        chk("reset_underflow", 32'(uf), 32'd0);
        chk("reset_sof", 32'(sof), 32'd0);
        chk("reset_hs_pos", 32'(hs2), 32'd0);
        chk("reset_vs_pos", 32'(vs2), 32'd0);
        rst = 1'b0;

        for (int c = 0; c < 48; c++) begin
            #1;
            chk($sformatf("ready[%0d]", c), 32'(rdy), 32'(tbl[c].de));
            cycle(tbl[c].vld);
            chk($sformatf("de[%0d]", c), 32'(de), 32'(tbl[c].de));
            chk($sformatf("hs[%0d]", c), 32'(hs), 32'(tbl[c].hs));
            chk($sformatf("vs[%0d]", c), 32'(vs), 32'(tbl[c].vs));
            chk($sformatf("sof[%0d]", c), 32'(sof), 32'(tbl[c].sof));
            chk($sformatf("data[%0d]", c), 32'(vdata), 32'(tbl[c].data));
            chk($sformatf("hs_pos[%0d]", c), 32'(hs2), 32'(!tbl[c].hs));
            chk($sformatf("vs_pos[%0d]", c), 32'(vs2), 32'(!tbl[c].vs));
            if (tbl[c].de) begin
                chk($sformatf("x[%0d]", c), 32'(vx), 32'(tbl[c].x));
                chk($sformatf("y[%0d]", c), 32'(vy), 32'(tbl[c].y));
            end
        end
        chk("no_underflow_frame", 32'(uf), 32'd0);

        // Underflow frame: source starts at 13; 5th active slot (line 1, col 0) is starved.
        for (int c = 0; c < 8; c++) cycle(1'b1);
        cycle(1'b0);
        chk("uf_slot_de", 32'(de), 32'd1);
        chk("uf_slot_data", 32'(vdata), 32'd0);
        chk("uf_slot_flag", 32'(uf), 32'd1);
        cycle(1'b1);
        chk("uf_next_data", 32'(vdata), 32'd17);
        chk("uf_next_x", 32'(vx), 32'd1);
        chk("uf_next_y", 32'(vy), 32'd1);
        chk("uf_sticky", 32'(uf), 32'd1);
        underflow_clr = 1'b1;
        cycle(1'b1);
        chk("uf_cleared", 32'(uf), 32'd0);
        cycle(1'b0);
        chk("uf_set_wins", 32'(uf), 32'd1);
        underflow_clr = 1'b0;
        for (int c = 12; c < 48; c++) cycle(1'b1);
        chk("uf_end_frame", 32'(uf), 32'd1);

        // en drop mid-line 1, then re-assert.
        for (int c = 0; c < 9; c++) cycle(1'b1);
        en = 1'b0;
        #1;
        chk("en_off_ready", 32'(rdy), 32'd0);
        cycle(1'b1);
        chk("en_off_de", 32'(de), 32'd0);
        chk("en_off_hs", 32'(hs), 32'd1);
        chk("en_off_vs", 32'(vs), 32'd1);
        chk("en_off_data", 32'(vdata), 32'd0);
        chk("en_off_hs_pos", 32'(hs2), 32'd0);
        cycle(1'b1);
        chk("en_off_de2", 32'(de), 32'd0);
        chk("en_off_sof", 32'(sof), 32'd0);
        en = 1'b1;
        #1;
        chk("en_on_ready", 32'(rdy), 32'd1);
        held = src;
        cycle(1'b1);
        chk("en_on_sof", 32'(sof), 32'd1);
        chk("en_on_de", 32'(de), 32'd1);
        chk("en_on_x", 32'(vx), 32'd0);
        chk("en_on_y", 32'(vy), 32'd0);
        chk("en_on_data", 32'(vdata), 32'(held));
        cycle(1'b1);
        chk("en_on_x1", 32'(vx), 32'd1);
        chk("en_on_sof_pulse", 32'(sof), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
